// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the two-requester memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBusyIf = 2'd1,
    StBusyLs = 2'd2
  } state_e;

  typedef enum logic {
    OwnerIfu = 1'b0,
    OwnerLsu = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU onto one memory port with a single outstanding transaction.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the LSU always wins ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 ifu_req_valid,
  output logic                 ifu_req_ready,
  input  logic [AddrWidth-1:0] ifu_addr,
  output logic                 ifu_rsp_valid,
  input  logic                 ifu_rsp_ready,
  output logic [DataWidth-1:0] ifu_rdata,

  input  logic                 lsu_req_valid,
  output logic                 lsu_req_ready,
  input  logic [AddrWidth-1:0] lsu_addr,
  input  logic [DataWidth-1:0] lsu_wdata,
  input  logic [StrbWidth-1:0] lsu_wmask,
  output logic                 lsu_rsp_valid,
  input  logic                 lsu_rsp_ready,
  output logic [DataWidth-1:0] lsu_rdata,

  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic [StrbWidth-1:0] mem_wmask,
  input  logic                 mem_rsp_valid,
  output logic                 mem_rsp_ready,
  input  logic [DataWidth-1:0] mem_rdata
);

  state_e state_q, state_d;
  logic   grant_lsu;
  logic   req_accept;

`ifdef ARB_RR_EN
  owner_e last_q, last_d;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    if (lsu_req_valid && ifu_req_valid) begin
      grant_lsu = (last_q == OwnerIfu);
    end else begin
      grant_lsu = lsu_req_valid;
    end
  end

  always_comb begin
    last_d = last_q;
    if (req_accept) begin
      last_d = grant_lsu ? OwnerLsu : OwnerIfu;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OwnerIfu;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant_lsu = lsu_req_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced to their idle, no-request values while rst is high.
  always_comb begin
    state_d       = state_q;
    req_accept    = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    lsu_rdata     = '0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    mem_rsp_ready = 1'b0;

    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (grant_lsu) begin
            mem_req_valid = 1'b1;
            mem_addr      = lsu_addr;
            mem_wdata     = lsu_wdata;
            mem_wmask     = lsu_wmask;
            lsu_req_ready = mem_req_ready;
            if (mem_req_ready) begin
              req_accept = 1'b1;
              state_d    = StBusyLs;
            end
          end else if (ifu_req_valid) begin
            mem_req_valid = 1'b1;
            mem_addr      = ifu_addr;
            ifu_req_ready = mem_req_ready;
            if (mem_req_ready) begin
              req_accept = 1'b1;
              state_d    = StBusyIf;
            end
          end
        end

        StBusyIf: begin
          ifu_rsp_valid = mem_rsp_valid;
          ifu_rdata     = mem_rdata;
          mem_rsp_ready = ifu_rsp_ready;
          if (mem_rsp_valid && ifu_rsp_ready) begin
            state_d = StIdle;
          end
        end

        StBusyLs: begin
          lsu_rsp_valid = mem_rsp_valid;
          lsu_rdata     = mem_rdata;
          mem_rsp_ready = lsu_rsp_ready;
          if (mem_rsp_valid && lsu_rsp_ready) begin
            state_d = StIdle;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; tie-order expectations follow ARB_RR_EN.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rdata     (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b0;
    lsu_addr      = '0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    lsu_rsp_ready = 1'b1;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;

    // Reset: outputs quiet even with a request pending.
    tick();
    tick();
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    settle();

    // IFU-only fetch, response three cycles later.
    check("if_mem_req_valid", 32'(mem_req_valid), 32'd1);
    check("if_mem_addr", mem_addr, 32'h8000_0000);
    check("if_mem_wmask", 32'(mem_wmask), 32'd0);
    check("if_req_ready", 32'(ifu_req_ready), 32'd1);
    check("if_lsu_req_ready", 32'(lsu_req_ready), 32'd0);
    tick();
    ifu_req_valid = 1'b0;
    settle();
    check("if_state_busy", 32'(dut.state_q), 32'(StBusyIf));
    check("if_busy_mem_req_valid", 32'(mem_req_valid), 32'd0);
    tick();
    check("if_wait_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0000_0413;
    settle();
    check("if_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
    check("if_rdata", ifu_rdata, 32'h0000_0413);
    check("if_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
    check("if_lsu_rdata", lsu_rdata, 32'd0);
    check("if_mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    tick();
    check("if_back_idle", 32'(dut.state_q), 32'(StIdle));
    // Stray response in idle is not taken.
    check("stray_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    check("stray_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    mem_rsp_valid = 1'b0;

    // Simultaneous requests: LSU store first, then IFU.
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 4'hF;
    settle();
    check("tie_mem_addr", mem_addr, 32'h8000_1000);
    check("tie_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("tie_mem_wmask", 32'(mem_wmask), 32'hF);
    check("tie_lsu_req_ready", 32'(lsu_req_ready), 32'd1);
    check("tie_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
    tick();
    lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h0000_0001;
    lsu_rsp_ready = 1'b0;
    settle();
    check("ls_busy_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
    check("ls_busy_mem_req_valid", 32'(mem_req_valid), 32'd0);
    // LSU back-pressure holds the transaction for four cycles.
    for (int i = 0; i < 4; i++) begin
      check("bp_state", 32'(dut.state_q), 32'(StBusyLs));
      check("bp_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd1);
      check("bp_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
      check("bp_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
      tick();
    end
    lsu_rsp_ready = 1'b1;
    settle();
    check("ls_mem_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    check("ls_rdata", lsu_rdata, 32'h0000_0001);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    check("ls_back_idle", 32'(dut.state_q), 32'(StIdle));
    check("if2_req_ready", 32'(ifu_req_ready), 32'd1);
    check("if2_mem_addr", mem_addr, 32'h8000_0004);
    tick();
    ifu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    settle();
    check("if2_state", 32'(dut.state_q), 32'(StBusyIf));
    tick();
    mem_rsp_valid = 1'b0;

    // Memory stall: request not accepted, then withdrawn.
    ifu_req_valid = 1'b1;
    mem_req_ready = 1'b0;
    settle();
    check("stall_mem_req_valid", 32'(mem_req_valid), 32'd1);
    check("stall_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
    tick();
    check("stall_state", 32'(dut.state_q), 32'(StIdle));
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    check("drop_state", 32'(dut.state_q), 32'(StIdle));
    check("drop_mem_req_valid", 32'(mem_req_valid), 32'd0);

    // Six back-to-back ties: RR alternates LSU/IFU, fixed priority always LSU.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    mem_rsp_valid = 1'b1;
    settle();
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_RR_EN
      check("rr_lsu_grant", 32'(lsu_req_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_ifu_grant", 32'(ifu_req_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
`else
      check("fp_lsu_grant", 32'(lsu_req_ready), 32'd1);
      check("fp_ifu_grant", 32'(ifu_req_ready), 32'd0);
`endif
      tick();
      check("seq_busy_req_ready", 32'(lsu_req_ready | ifu_req_ready), 32'd0);
      tick();
    end

    // Reset mid-fetch with a response pending.
    lsu_req_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    settle();
    check("pre_rst_grant", 32'(ifu_req_ready), 32'd1);
    tick();
    ifu_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1234_5678;
    settle();
    check("pre_rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
    rst           = 1'b1;
    lsu_req_valid = 1'b1;
    settle();
    check("rst_mid_state", 32'(dut.state_q), 32'(StIdle));
    check("rst_mid_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    check("rst_mid_ifu_rdata", ifu_rdata, 32'd0);
    check("rst_mid_mem_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    check("rst_mid_mem_req_valid", 32'(mem_req_valid), 32'd0);
    tick();
    rst           = 1'b0;
    lsu_req_valid = 1'b0;
    settle();
    check("post_rst_state", 32'(dut.state_q), 32'(StIdle));
    check("post_rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    mem_rsp_valid = 1'b0;

    // After reset the first tie goes to the LSU in both builds.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    settle();
    check("post_rst_tie_lsu", 32'(lsu_req_ready), 32'd1);
    check("post_rst_tie_ifu", 32'(ifu_req_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; all addresses and data 32 bits, write strobe 4 bits, defined in the shared package.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ifu_req_valid  in  1  fetch read request valid.
REQ-005 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-006 ifu_addr  in  32  fetch address.
REQ-007 ifu_rsp_valid  out  1  fetch data valid.
REQ-008 ifu_rsp_ready  in  1  fetch side can take data.
REQ-009 ifu_rdata  out  32  fetched instruction word.
REQ-010 lsu_req_valid  in  1  load/store request valid.
REQ-011 lsu_req_ready  out  1  load/store request accepted.
REQ-012 lsu_addr  in  32  load/store address.
REQ-013 lsu_wdata  in  32  store data.
REQ-014 lsu_wmask  in  4  byte strobe; nonzero = write, zero = read.
REQ-015 lsu_rsp_valid  out  1  load data / store ack valid.
REQ-016 lsu_rsp_ready  in  1  LSU can take response.
REQ-017 lsu_rdata  out  32  load data.
REQ-018 mem_req_valid  out  1  request to shared memory port.
REQ-019 mem_req_ready  in  1  memory accepts request.
REQ-020 mem_addr / mem_wdata / mem_wmask  out  32/32/4  forwarded request fields (wmask 0 for fetch).
REQ-021 mem_rsp_valid  in  1  memory response valid.
REQ-022 mem_rsp_ready  out  1  arbiter takes response.
REQ-023 mem_rdata  in  32  memory read data.

Function
REQ-024 FSM states IDLE, BUSY_IF, BUSY_LS; exactly one outstanding memory transaction.
REQ-025 IDLE: winner's req fields and valid drive mem_* combinationally; winner's req_ready = mem_req_ready; loser's req_ready = 0.
REQ-026 IDLE priority: LSU wins when both valid (fixed-priority build).
REQ-027 On mem_req_valid && mem_req_ready, owner latched; next state BUSY_IF or BUSY_LS.
REQ-028 BUSY_x: mem_req_valid = 0, both req_ready = 0; owner rsp_valid = mem_rsp_valid, owner rdata = mem_rdata, mem_rsp_ready = owner rsp_ready; non-owner rsp_valid = 0.
REQ-029 On mem_rsp_valid && mem_rsp_ready in BUSY_x, next state IDLE; new grant earliest next cycle (one idle cycle between transactions, minimum 2 cycles per transaction).
REQ-030 IDLE: mem_rsp_ready = 0, stray mem_rsp_valid ignored.
REQ-031 Requester dropping valid before acceptance: no grant, no state change.
REQ-032 Non-owner rdata driven 0.

Reset
REQ-033 rst asserted any cycle (incl. mid-transaction): state IDLE immediately, owner and last-grant cleared; all outputs derived combinationally from IDLE with no requests (0); in-flight memory response discarded.

Configuration
REQ-034 ARB_RR_EN defined: round-robin -- when both valid in IDLE, the requester not granted last wins; last-grant register updates on each accepted request, resets to IFU (LSU wins first tie).
REQ-035 ARB_RR_EN undefined: fixed LSU priority per REQ-026; no last-grant register.

Structure
REQ-036 Shared package holds state enum (IDLE, BUSY_IF, BUSY_LS), owner enum, and ADDR/DATA/STRB width constants.
REQ-037 Single module; no sub-module (grant logic too small to split).

Verification
REQ-038 IFU alone reads 0x8000_0000, memory returns 0x0000_0413 after 3 cycles -> ifu_rdata 0x0000_0413, lsu_rsp_valid stays 0.
REQ-039 Both valid same cycle, LSU store 0xDEAD_BEEF mask 0xF to 0x8000_1000 -> LSU granted first, IFU granted the cycle after LSU response completes.
REQ-040 ARB_RR_EN, both requesters continuously valid for 6 transactions -> grants alternate LSU, IFU, LSU, IFU, LSU, IFU.
REQ-041 mem_rsp_valid held while lsu_rsp_ready = 0 for 4 cycles -> state stays BUSY_LS, lsu_rsp_valid = 1 throughout, returns IDLE on handshake.
REQ-042 rst asserted in BUSY_IF with mem_rsp_valid = 1 -> all outputs 0 same cycle, state IDLE, no ifu_rsp_valid after rst deasserts.
